goldschmidt_seq: RTL and testbench
==================================

// Module: goldschmidt_seq
// PURPOSE
//  Control sequencer for the Goldschmidt fpdiv datapath.
//  It replaces the hand-driven mux selects and register enables with an FSM.
//  A start/busy/done handshake wraps the sequencer. Iteration count and multiplier latency are parameters.
//  Sits between the FP-unit issue logic and the fpdiv datapath (mux3/mux4 selects, A/B/REM enables).
// PARAMETERS
//  ITERS    5  refinement iterations (N*K / D*K pairs) after the initial-approximation (IA) step; >=1
//  MUL_LAT  1  multiplier latency in cycles; each step holds its selects MUL_LAT cycles; >=1
//  CNT_W    $clog2(ITERS+1)  width of iter_cnt (derived, do not override)
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      synchronous, active-low reset
//  start     in   1      request a divide; sampled only in IDLE
//  special   in   1      operand is zero/inf/NaN; sampled with start; skips the datapath
//  rm_in     in   1      rounding mode bit; sampled with start
//  abort     in   1      synchronous cancel of the operation in flight
//  sel_mux4  out  2      00=N*IA  01=D*IA  10=N*C  11=D*C
//  sel_mux3  out  2      00=IA operand  01=C-register operand  10=remainder path
//  en_a      out  1      numerator (A) register load strobe
//  en_b      out  1      denominator (B) register load strobe
//  en_rem    out  1      remainder register load strobe
//  rm        out  1      latched rounding mode to the rounding mux
//  iter_cnt  out  CNT_W  completed refinement iterations, 0..ITERS
//  busy      out  1      high from the cycle after start is accepted up to and including DONE
//  done      out  1      one-cycle pulse; the result is valid at final_ans
// BEHAVIOUR
//  Reset (reset==0 at an edge): state=IDLE.
//   All outputs 0: sel_mux4=00, sel_mux3=00, en_a/en_b/en_rem=0, rm=0, iter_cnt=0, busy=0, done=0.
//  States: IDLE, LOAD_N, LOAD_D, ITER_N, ITER_D, REM, DONE.
//  IDLE: start=1 latches rm_in into rm.
//   special=1 -> DONE. Else -> LOAD_N, clearing iter_cnt and the dwell counter.
//  Dwell counter (dw): every non-IDLE, non-DONE state lasts exactly MUL_LAT cycles.
//   Selects are held for the whole dwell.
//   The state's enable asserts only in the last dwell cycle (dw==MUL_LAT-1), then dw clears.
//  LOAD_N: sel_mux4=00, sel_mux3=00, en_a on last cycle -> LOAD_D.
//  LOAD_D: sel_mux4=01, sel_mux3=00, en_b on last cycle -> ITER_N.
//  ITER_N: sel_mux4=10, sel_mux3=01, en_a on last cycle -> ITER_D.
//  ITER_D: sel_mux4=11, sel_mux3=01, en_b on last cycle; iter_cnt++.
//   If iter_cnt(new)==ITERS -> REM, else -> ITER_N.
//  REM: sel_mux4=10, sel_mux3=10, en_rem on last cycle -> DONE.
//  DONE: done=1 for exactly one cycle; selects 00/00, enables 0 -> IDLE.
//  busy=1 in every state except IDLE.
//  At most one of en_a/en_b/en_rem is high in any cycle.
//  Enables are never high in IDLE or DONE.
//  Latency, start edge to done-high cycle: (3+2*ITERS)*MUL_LAT+1 cycles.
//   ITERS=5, MUL_LAT=1 -> 14. special path -> 1.
//  start while busy (including DONE): ignored, not queued.
//   A new start is accepted the cycle after DONE (in IDLE).
//  abort=1 in any non-IDLE state: next state IDLE.
//   No done pulse; iter_cnt and rm hold; all enables forced 0 in the abort cycle itself.
//  abort together with start in IDLE: abort wins, start is dropped.
//  reset mid-operation: same as abort, and additionally clears rm and iter_cnt.
//  iter_cnt saturates at ITERS and never wraps.
//  dw is $clog2(MUL_LAT+1) bits and never exceeds MUL_LAT-1.
// TESTING
//  T1 ITERS=5, MUL_LAT=1, start pulse, special=0.
//   sel_mux4 must be 00,01,(10,11)x5,10. sel_mux3 must be 00,00,01x10,10.
//   en_a x6, en_b x6, en_rem x1, done at cycle 14, iter_cnt=5.
//  T2 ITERS=5, MUL_LAT=3.
//   Each select held 3 cycles; enables only on the 3rd cycle; done at cycle 40; never two enables together.
//  T3 Abort at cycle 5 (in ITER_N).
//   Next cycle IDLE, busy=0, no done, no enables.
//   A start 2 cycles later runs a full 14-cycle op.
//  T4 start with special=1, rm_in=1.
//   done at cycle 1, rm=1, no en_a/en_b/en_rem ever high, iter_cnt=0.
//  T5 start re-asserted every cycle of an op (T1 config).
//   Exactly one done at cycle 14. The second op is accepted in IDLE and its done falls at cycle 29.
//  T6 reset=0 at cycle 7, then released.
//   All outputs 0 the next cycle, rm=0, iter_cnt=0.
//   A following start completes normally with a correct control trace.

Source files
------------

// File: rtl/goldschmidt_seq.sv
// Control sequencer for the Goldschmidt divider datapath: drives mux selects and the
// A/B/REM register strobes through IA load, ITERS refinement pairs and the remainder step.
module goldschmidt_seq #(
    parameter int unsigned ITERS   = 5,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned CNT_W   = $clog2(ITERS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             special,
    input  logic             rm_in,
    input  logic             abort,
    output logic [1:0]       sel_mux4,
    output logic [1:0]       sel_mux3,
    output logic             en_a,
    output logic             en_b,
    output logic             en_rem,
    output logic             rm,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW_W = $clog2(MUL_LAT + 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(ITERS);

    typedef enum logic [2:0] {
        StIdle,
        StLoadN,
        StLoadD,
        StIterN,
        StIterD,
        StRem,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [DW_W-1:0]  dw_q, dw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rm_q, rm_d;
    logic             last;
    logic             working;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            dw_q    <= '0;
            cnt_q   <= '0;
            rm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dw_q    <= dw_d;
            cnt_q   <= cnt_d;
            rm_q    <= rm_d;
        end
    end

    assign last    = (dw_q == DW_LAST);
    assign working = (state_q != StIdle) && (state_q != StDone);

    always_comb begin
        state_d  = state_q;
        dw_d     = dw_q;
        cnt_d    = cnt_q;
        rm_d     = rm_q;
        sel_mux4 = 2'b00;
        sel_mux3 = 2'b00;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        done     = 1'b0;
        busy     = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    rm_d = rm_in;
                    if (special) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoadN;
                        cnt_d   = '0;
                        dw_d    = '0;
                    end
                end
            end
            StLoadN: begin
                en_a = last;
                if (last) state_d = StLoadD;
            end
            StLoadD: begin
                sel_mux4 = 2'b01;
                en_b     = last;
                if (last) state_d = StIterN;
            end
            StIterN: begin
                sel_mux4 = 2'b10;
                sel_mux3 = 2'b01;
                en_a     = last;
                if (last) state_d = StIterD;
            end
            StIterD: begin
                sel_mux4 = 2'b11;
                sel_mux3 = 2'b01;
                en_b     = last;
                if (last) begin
                    cnt_d   = (cnt_q == ITER_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = (cnt_d == ITER_MAX) ? StRem : StIterN;
                end
            end
            StRem: begin
                sel_mux4 = 2'b10;
                sel_mux3 = 2'b10;
                en_rem   = last;
                if (last) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (working) begin
            dw_d = last ? '0 : dw_q + DW_W'(1);
        end

        // Abort drops the step in flight: no strobe, no count, no done pulse.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            dw_d    = '0;
            cnt_d   = cnt_q;
            en_a    = 1'b0;
            en_b    = 1'b0;
            en_rem  = 1'b0;
            done    = 1'b0;
        end
    end

    assign rm       = rm_q;
    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_goldschmidt_seq.sv
// Scoreboard bench: two sequencers (MUL_LAT=1 and 3) share stimulus; a monitor checks
// every done pulse against queued expectations (cycle, rm, iter_cnt, control-trace signature).
module tb_goldschmidt_seq;

    localparam int unsigned ITERS = 5;
    localparam int unsigned CW    = $clog2(ITERS + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, special, rm_in, abort;
    logic [1:0]    sel4 [2];
    logic [1:0]    sel3 [2];
    logic          ea   [2];
    logic          eb   [2];
    logic          er   [2];
    logic          rmo  [2];
    logic          bsy  [2];
    logic          dn   [2];
    logic [CW-1:0] ic   [2];

    goldschmidt_seq #(.ITERS(ITERS), .MUL_LAT(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .special(special), .rm_in(rm_in),
        .abort(abort), .sel_mux4(sel4[0]), .sel_mux3(sel3[0]), .en_a(ea[0]), .en_b(eb[0]),
        .en_rem(er[0]), .rm(rmo[0]), .iter_cnt(ic[0]), .busy(bsy[0]), .done(dn[0])
    );

    goldschmidt_seq #(.ITERS(ITERS), .MUL_LAT(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .special(special), .rm_in(rm_in),
        .abort(abort), .sel_mux4(sel4[1]), .sel_mux3(sel3[1]), .en_a(ea[1]), .en_b(eb[1]),
        .en_rem(er[1]), .rm(rmo[1]), .iter_cnt(ic[1]), .busy(bsy[1]), .done(dn[1])
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int unsigned done_cyc;
        logic        rm;
        int unsigned it;
        int unsigned sig;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int unsigned sig_acc [2];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sig_step(input int unsigned s, input logic [1:0] m4,
                                             input logic [1:0] m3, input logic a,
                                             input logic b, input logic r);
        return s * 31 + {25'd0, m4, m3, a, b, r} + 1;
    endfunction

    // Expected control trace: LOAD_N, LOAD_D, (ITER_N, ITER_D) x ITERS, REM, then DONE.
    function automatic int unsigned model_sig(input int ml, input bit sp);
        int unsigned s = 0;
        if (!sp) begin
            for (int st = 0; st < 3 + 2 * int'(ITERS); st++) begin
                logic [1:0] m4;
                logic [1:0] m3;
                int en;
                if (st == 0) begin
                    m4 = 2'd0; m3 = 2'd0; en = 0;
                end else if (st == 1) begin
                    m4 = 2'd1; m3 = 2'd0; en = 1;
                end else if (st == 2 + 2 * int'(ITERS)) begin
                    m4 = 2'd2; m3 = 2'd2; en = 2;
                end else if (st % 2 == 0) begin
                    m4 = 2'd2; m3 = 2'd1; en = 0;
                end else begin
                    m4 = 2'd3; m3 = 2'd1; en = 1;
                end
                for (int c = 0; c < ml; c++) begin
                    s = sig_step(s, m4, m3, (c == ml - 1) && (en == 0),
                                 (c == ml - 1) && (en == 1), (c == ml - 1) && (en == 2));
                end
            end
        end
        s = sig_step(s, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        return s;
    endfunction

    task automatic push(input int k, input int unsigned dcyc, input logic r,
                        input int unsigned it, input int unsigned sg);
        exp_t e;
        e.done_cyc = dcyc;
        e.rm       = r;
        e.it       = it;
        e.sig      = sg;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   have;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (!bsy[k]) begin
                    sig_acc[k] = 0;
                    chk($sformatf("idle_outputs_u%0d", k),
                        {26'd0, sel4[k], sel3[k], ea[k], eb[k], er[k], dn[k]}, 0);
                end else begin
                    chk($sformatf("enable_onehot_u%0d", k),
                        ($countones({ea[k], eb[k], er[k]}) <= 1), 1);
                    sig_acc[k] = sig_step(sig_acc[k], sel4[k], sel3[k], ea[k], eb[k], er[k]);
                    if (dn[k]) begin
                        have = 1'b0;
                        if (k == 0 && q0.size() > 0) begin
                            e = q0.pop_front(); have = 1'b1;
                        end else if (k == 1 && q1.size() > 0) begin
                            e = q1.pop_front(); have = 1'b1;
                        end
                        if (!have) begin
                            vectors++;
                            errors++;
                            $display("FAIL unexpected_done_u%0d: got done at cycle %0d expected none",
                                     k, cyc);
                        end else begin
                            chk($sformatf("done_cycle_u%0d", k), cyc, e.done_cyc);
                            chk($sformatf("done_rm_u%0d", k), rmo[k], e.rm);
                            chk($sformatf("done_iter_cnt_u%0d", k), ic[k], e.it);
                            chk($sformatf("trace_sig_u%0d", k), sig_acc[k], e.sig);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_u%0d", name, k),
                {21'd0, sel4[k], sel3[k], ea[k], eb[k], er[k], rmo[k], bsy[k], dn[k], ic[k]}, 0);
        end
    endtask

    // Drives a one-cycle start and queues the expected completion on both units.
    task automatic issue(input bit sp, input bit r);
        start   = 1'b1;
        special = sp;
        rm_in   = r;
        push(0, cyc + (sp ? 1 : 14), r, sp ? 0 : ITERS, model_sig(1, sp));
        push(1, cyc + (sp ? 1 : 40), r, sp ? 0 : ITERS, model_sig(3, sp));
        tick(1);
        start   = 1'b0;
        special = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bsy[0] || bsy[1] || q0.size() != 0 || q1.size() != 0) && n < 200) begin
            tick(1);
            n++;
        end
        chk("wait_idle_in_budget", (n < 200), 1);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        special = 1'b0;
        rm_in   = 1'b0;
        abort   = 1'b0;
        tick(3);
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);

        // Special operand: done one cycle after start, rm latched, datapath untouched.
        issue(1'b1, 1'b1);
        wait_idle();
        chk("special_rm_hold", rmo[0], 1);

        // Full divide on both latencies.
        issue(1'b0, 1'b0);
        wait_idle();
        tick(2);

        // Abort during cycle 5 (u1 in ITER_N, last dwell cycle).
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_enables_u1", {ea[0], eb[0], er[0]}, 0);
        chk("abort_cycle_busy_u1", bsy[0], 1);
        chk("abort_cycle_enables_u3", {ea[1], eb[1], er[1]}, 0);
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        chk("after_abort_busy_u1", bsy[0], 0);
        chk("after_abort_busy_u3", bsy[1], 0);
        chk("after_abort_iter_hold_u1", ic[0], 1);
        chk("after_abort_iter_hold_u3", ic[1], 0);
        chk("after_abort_rm_hold", rmo[0], 0);
        tick(1);
        issue(1'b0, 1'b0);
        wait_idle();
        tick(2);

        // Start held high across a whole op, including the DONE cycle.
        start = 1'b1;
        rm_in = 1'b1;
        push(0, cyc + 14, 1'b1, ITERS, model_sig(1, 1'b0));
        push(0, cyc + 29, 1'b1, ITERS, model_sig(1, 1'b0));
        push(1, cyc + 40, 1'b1, ITERS, model_sig(3, 1'b0));
        tick(16);
        start = 1'b0;
        rm_in = 1'b0;
        wait_idle();
        tick(2);

        // Reset mid-operation at cycle 7, then a clean op.
        start = 1'b1;
        rm_in = 1'b1;
        tick(1);
        start = 1'b0;
        rm_in = 1'b0;
        tick(6);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("after_mid_reset");
        tick(1);
        issue(1'b0, 1'b0);
        wait_idle();
        tick(2);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
